// File: rtl/fault_pkg.sv
// Shared types and constants for the fault-injection sweep controller.
// The result record bundles everything the consumer needs for one injected bit.
package fault_pkg;

    localparam int AES_LATENCY = 21;
    localparam int CT_W        = 128;
    localparam int BIT_W       = 7;
    localparam int NBYTES      = CT_W / 8;
    localparam int NB_W        = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GOLDEN,
        ST_INJECT,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [BIT_W-1:0] bit_idx;
        logic [CT_W-1:0]  ct;
        logic [CT_W-1:0]  diff;
        logic [NB_W-1:0]  nbytes;
    } result_t;

endpackage

// File: rtl/byte_diff_count.sv
// Counts the bytes of a difference vector that carry at least one set bit.
// Purely combinational; the caller registers the result.
module byte_diff_count
    import fault_pkg::*;
(
    input  logic [CT_W-1:0] diff,
    output logic [NB_W-1:0] nbytes
);

    logic [NBYTES-1:0] byte_nz;

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
            assign byte_nz[gi] = |diff[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        nbytes = '0;
        for (int i = 0; i < NBYTES; i++) begin
            nbytes = nbytes + NB_W'(byte_nz[i]);
        end
    end

endmodule

// File: rtl/fault_sweep_ctrl.sv
// Fault campaign controller: captures a golden ciphertext, then injects one bit
// flip at a time into the core and streams out one diff record per bit.
module fault_sweep_ctrl
    import fault_pkg::*;
#(
    parameter int LATENCY = AES_LATENCY
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIT_W-1:0] bit_lo,
    input  logic [BIT_W-1:0] bit_hi,
    output logic             fault_en,
    output logic [BIT_W-1:0] fault_bit,
    input  logic [CT_W-1:0]  ciphertext,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [BIT_W-1:0] res_bit,
    output logic [CT_W-1:0]  res_ct,
    output logic [CT_W-1:0]  res_diff,
    output logic [NB_W-1:0]  res_nbytes,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(LATENCY + 2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] cur_q, cur_d;
    logic [BIT_W-1:0] hi_q, hi_d;
    logic [CT_W-1:0]  golden_q, golden_d;
    result_t          res_q, res_d;
    logic             fault_en_q, fault_en_d;
    logic [BIT_W-1:0] fault_bit_q, fault_bit_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             empty_range;

    logic [CT_W-1:0]  diff_now;
    logic [NB_W-1:0]  nbytes_now;

    assign diff_now = ciphertext ^ golden_q;

    byte_diff_count u_byte_diff_count (
        .diff   (diff_now),
        .nbytes (nbytes_now)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_d       = cur_q;
        hi_d        = hi_q;
        golden_d    = golden_q;
        res_d       = res_q;
        empty_range = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (bit_lo <= bit_hi) begin
                        hi_d    = bit_hi;
                        cur_d   = bit_lo;
                        cnt_d   = '0;
                        state_d = ST_GOLDEN;
                    end else begin
                        empty_range = 1'b1;
                    end
                end
            end
            // LATENCY+1 quiet cycles flush any fault still travelling through the core
            ST_GOLDEN: begin
                if (cnt_q == CNT_W'(LATENCY)) begin
                    golden_d = ciphertext;
                    state_d  = ST_INJECT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_INJECT: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            // The core sampled fault_en on the edge that entered WAIT; its result
            // is on ciphertext at the LATENCY-th edge after that.
            ST_WAIT: begin
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    res_d.bit_idx = cur_q;
                    res_d.ct      = ciphertext;
                    res_d.diff    = diff_now;
                    res_d.nbytes  = nbytes_now;
                    state_d       = ST_EMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EMIT: begin
                if (res_valid_q && res_ready) begin
                    if (cur_q == hi_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_d   = cur_q + BIT_W'(1);
                        state_d = ST_INJECT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        fault_en_d  = (state_d == ST_INJECT);
        fault_bit_d = (state_d == ST_INJECT) ? cur_d : fault_bit_q;
        res_valid_d = (state_d == ST_EMIT);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE) || empty_range;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cur_q       <= '0;
            hi_q        <= '0;
            golden_q    <= '0;
            res_q       <= '0;
            fault_en_q  <= 1'b0;
            fault_bit_q <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            hi_q        <= hi_d;
            golden_q    <= golden_d;
            res_q       <= res_d;
            fault_en_q  <= fault_en_d;
            fault_bit_q <= fault_bit_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign fault_en   = fault_en_q;
    assign fault_bit  = fault_bit_q;
    assign res_valid  = res_valid_q;
    assign res_bit    = res_q.bit_idx;
    assign res_ct     = res_q.ct;
    assign res_diff   = res_q.diff;
    assign res_nbytes = res_q.nbytes;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fault_sweep_ctrl.sv
// Directed sweeps against a stub core whose faulty output is golden ^ mask[bit],
// with random golden values and masks.
module tb_fault_sweep_ctrl;
    import fault_pkg::*;

    localparam int LAT = AES_LATENCY;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [BIT_W-1:0] bit_lo = '0;
    logic [BIT_W-1:0] bit_hi = '0;
    logic             res_ready = 1'b1;
    logic             fault_en;
    logic [BIT_W-1:0] fault_bit;
    logic [CT_W-1:0]  ciphertext;
    logic             res_valid;
    logic [BIT_W-1:0] res_bit;
    logic [CT_W-1:0]  res_ct;
    logic [CT_W-1:0]  res_diff;
    logic [NB_W-1:0]  res_nbytes;
    logic             busy;
    logic             done;

    int checks = 0;
    int failures = 0;

    fault_sweep_ctrl #(.LATENCY(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bit_lo     (bit_lo),
        .bit_hi     (bit_hi),
        .fault_en   (fault_en),
        .fault_bit  (fault_bit),
        .ciphertext (ciphertext),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_bit    (res_bit),
        .res_ct     (res_ct),
        .res_diff   (res_diff),
        .res_nbytes (res_nbytes),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Stub core: inputs sampled at an edge come out LAT edges later (counting that edge).
    logic [CT_W-1:0]  golden_g = '0;
    logic [CT_W-1:0]  mask_m [CT_W];
    logic             fe_p [LAT];
    logic [BIT_W-1:0] fb_p [LAT];

    always @(posedge clk) begin
        fe_p[0] <= fault_en;
        fb_p[0] <= fault_bit;
        for (int i = 1; i < LAT; i++) begin
            fe_p[i] <= fe_p[i-1];
            fb_p[i] <= fb_p[i-1];
        end
    end

    assign ciphertext = fe_p[LAT-1] ? (golden_g ^ mask_m[fb_p[LAT-1]]) : golden_g;

    // Observation of the DUT, one sample per cycle on the falling edge.
    int               cyc = 0;
    int               inj_cyc_q [$];
    logic [BIT_W-1:0] inj_bit_q [$];
    logic [BIT_W-1:0] rb_q [$];
    logic [CT_W-1:0]  rct_q [$];
    logic [CT_W-1:0]  rdiff_q [$];
    logic [NB_W-1:0]  rnb_q [$];
    int               hs_cyc_q [$];
    int               hold_q [$];
    int               done_cyc_q [$];
    int               fe_run_err = 0;
    int               fe_during_valid = 0;
    int               stab_err = 0;
    int               valid_cycles = 0;

    initial begin
        logic prev_fe;
        logic prev_valid;
        logic [BIT_W+2*CT_W+NB_W-1:0] prev_rec;
        int hold;
        prev_fe = 1'b0;
        prev_valid = 1'b0;
        prev_rec = '0;
        hold = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_fe = 1'b0;
                prev_valid = 1'b0;
                hold = 0;
            end else begin
                if (fault_en) begin
                    inj_cyc_q.push_back(cyc);
                    inj_bit_q.push_back(fault_bit);
                    if (prev_fe) fe_run_err++;
                    if (res_valid) fe_during_valid++;
                end
                if (res_valid) begin
                    valid_cycles++;
                    hold++;
                    if (prev_valid && ({res_bit, res_ct, res_diff, res_nbytes} != prev_rec)) stab_err++;
                end
                if (res_valid && res_ready) begin
                    rb_q.push_back(res_bit);
                    rct_q.push_back(res_ct);
                    rdiff_q.push_back(res_diff);
                    rnb_q.push_back(res_nbytes);
                    hs_cyc_q.push_back(cyc);
                    hold_q.push_back(hold);
                    hold = 0;
                    prev_valid = 1'b0;
                end else begin
                    prev_valid = res_valid;
                end
                prev_rec = {res_bit, res_ct, res_diff, res_nbytes};
                prev_fe = fault_en;
                if (done) done_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CT_W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int nz_bytes(input logic [CT_W-1:0] v);
        int n = 0;
        for (int k = 0; k < NBYTES; k++) if (v[8*k +: 8] != 8'h00) n++;
        return n;
    endfunction

    // Fresh golden value and per-bit fault masks with a random mix of untouched bytes.
    task automatic new_data();
        logic [CT_W-1:0] m;
        golden_g = rand128();
        for (int b = 0; b < CT_W; b++) begin
            m = rand128();
            for (int k = 0; k < NBYTES; k++) if ($urandom_range(0, 2) == 0) m[8*k +: 8] = 8'h00;
            m[b] = 1'b1;
            mask_m[b] = m;
        end
    endtask

    int base_inj, base_rec, base_done, base_hold;

    task automatic snapshot();
        base_inj  = inj_cyc_q.size();
        base_rec  = rb_q.size();
        base_done = done_cyc_q.size();
        base_hold = hold_q.size();
    endtask

    task automatic pulse_start(input int lo, input int hi);
        @(posedge clk); #1;
        bit_lo = BIT_W'(lo);
        bit_hi = BIT_W'(hi);
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // Runs one sweep to its done pulse; record bp_rec sees res_ready low for bp_len cycles.
    task automatic run_sweep(input int lo, input int hi, input int bp_rec, input int bp_len);
        int bp_left;
        snapshot();
        pulse_start(lo, hi);
        bp_left = bp_len;
        for (int c = 0; c < 6000 && done_cyc_q.size() == base_done; c++) begin
            if (res_valid && (rb_q.size() - base_rec) == bp_rec && bp_left > 0) begin
                res_ready = 1'b0;
                bp_left--;
            end else begin
                res_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        check($sformatf("sweep_%0d_%0d_completes", lo, hi), done_cyc_q.size() > base_done, 1);
    endtask

    // Compares the records and injections of the last sweep against the mask model.
    task automatic check_records(input int lo, input int hi);
        int n;
        int exp_b;
        n = hi - lo + 1;
        check("record_count", rb_q.size() - base_rec, n);
        check("inject_count", inj_bit_q.size() - base_inj, n);
        for (int i = 0; i < n && base_rec + i < rb_q.size(); i++) begin
            exp_b = lo + i;
            check($sformatf("res_bit[%0d]", i), rb_q[base_rec+i], exp_b);
            check($sformatf("res_diff[%0d]", i), rdiff_q[base_rec+i], mask_m[exp_b]);
            check($sformatf("res_ct[%0d]", i), rct_q[base_rec+i], golden_g ^ mask_m[exp_b]);
            check($sformatf("res_nbytes[%0d]", i), rnb_q[base_rec+i], nz_bytes(mask_m[exp_b]));
        end
        for (int i = 0; i < n && base_inj + i < inj_bit_q.size(); i++) begin
            check($sformatf("fault_bit[%0d]", i), inj_bit_q[base_inj+i], lo + i);
        end
        check("done_pulses", done_cyc_q.size() - base_done, 1);
    endtask

    initial begin
        int min_gap;
        int vbase;
        int got;
        logic [CT_W-1:0] exp_diff;

        for (int b = 0; b < CT_W; b++) mask_m[b] = '0;
        new_data();

        // Reset held long enough to fill the stub pipeline with idle samples.
        repeat (LAT + 4) @(posedge clk);
        @(negedge clk);
        check("rst_fault_en", fault_en, 0);
        check("rst_fault_bit", fault_bit, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_bit", res_bit, 0);
        check("rst_res_ct", res_ct, 0);
        check("rst_res_diff", res_diff, 0);
        check("rst_res_nbytes", res_nbytes, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single bit.
        new_data();
        run_sweep(5, 5, -1, 0);
        check_records(5, 5);
        check("single_fe_one_cycle", fe_run_err, 0);
        repeat (2) @(negedge clk);
        check("single_busy_after", busy, 0);
        check("single_done_low_after", done, 0);

        // Full sweep 0..127 with res_ready high.
        new_data();
        run_sweep(0, 127, -1, 0);
        check_records(0, 127);
        min_gap = 1 << 30;
        for (int i = base_inj + 1; i < inj_cyc_q.size(); i++) begin
            if (inj_cyc_q[i] - inj_cyc_q[i-1] < min_gap) min_gap = inj_cyc_q[i] - inj_cyc_q[i-1];
        end
        check("full_spacing_ge_lat2", min_gap >= LAT + 2, 1);
        if (hs_cyc_q.size() > 0 && done_cyc_q.size() > 0)
            check("full_done_after_last_hs", done_cyc_q[done_cyc_q.size()-1] - hs_cyc_q[hs_cyc_q.size()-1], 1);
        check("full_fe_one_cycle", fe_run_err, 0);

        // Empty range.
        snapshot();
        vbase = valid_cycles;
        pulse_start(10, 3);
        @(negedge clk);
        check("empty_done_next_cycle", done, 1);
        check("empty_not_busy", busy, 0);
        @(negedge clk);
        check("empty_done_one_cycle", done, 0);
        repeat (LAT + 5) @(negedge clk);
        check("empty_no_inject", inj_cyc_q.size() - base_inj, 0);
        check("empty_no_valid", valid_cycles - vbase, 0);
        check("empty_done_count", done_cyc_q.size() - base_done, 1);

        // Backpressure on record 1.
        new_data();
        run_sweep(0, 2, 1, 50);
        check_records(0, 2);
        check("bp_stable", stab_err, 0);
        check("bp_no_inject_while_valid", fe_during_valid, 0);
        if (hold_q.size() > base_hold + 1) check("bp_hold_len", hold_q[base_hold+1], 51);

        // Diff count with a fixed two-byte fault pattern.
        new_data();
        exp_diff = {8'hFF, 112'h0, 8'h01};
        mask_m[42] = exp_diff;
        run_sweep(42, 42, -1, 0);
        check("dc_record_count", rb_q.size() - base_rec, 1);
        if (rb_q.size() > base_rec) begin
            check("dc_nbytes", rnb_q[base_rec], 2);
            check("dc_diff", rdiff_q[base_rec], exp_diff);
        end

        // Reset during WAIT of bit 3, then a fresh 7..7 sweep.
        new_data();
        snapshot();
        pulse_start(3, 5);
        for (int c = 0; c < 200 && inj_cyc_q.size() == base_inj; c++) @(negedge clk);
        check("mw_reached_inject", inj_cyc_q.size() - base_inj, 1);
        if (inj_bit_q.size() > base_inj) check("mw_first_bit", inj_bit_q[base_inj], 3);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mw_fault_en", fault_en, 0);
        check("mw_res_valid", res_valid, 0);
        check("mw_busy", busy, 0);
        check("mw_res_diff", res_diff, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        got = rb_q.size();
        check("mw_no_record", got - base_rec, 0);
        run_sweep(7, 7, -1, 0);
        check_records(7, 7);

        // Reset while fault_en is high: it must fall without a clock edge.
        snapshot();
        pulse_start(20, 20);
        for (int c = 0; c < 200 && !fault_en; c++) @(negedge clk);
        check("mi_fault_en_seen", fault_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mi_fault_en_async", fault_en, 0);
        check("mi_fault_bit_async", fault_bit, 0);
        check("mi_busy_async", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (LAT + 5) @(negedge clk);
        check("mi_no_record", rb_q.size() - base_rec, 0);
        check("mi_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fault_sweep_ctrl.md
Name: fault_sweep_ctrl

Overview:
- Campaign controller wrapped around the faultable AES-128 core.
- Upstream role: drives the core's fault_en/fault_bit inputs, sweeping a programmed range of state bits one injection at a time.
- Downstream role: samples the resulting ciphertext, compares it against a fault-free golden ciphertext and emits one result record per injected bit over a valid/ready stream.
- Produces the raw data set for differential fault analysis.

Parameters:
- LATENCY, 21, clock edges from the core sampling state/key/fault inputs to the corresponding ciphertext appearing on its output.
- CT_W, 128, ciphertext/state width in bits.
- BIT_W, 7, fault_bit index width, log2(CT_W).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
- bit_lo  input  BIT_W  first bit to inject; sampled on start.
- bit_hi  input  BIT_W  last bit to inject, inclusive; sampled on start.
- fault_en  output  1  to the core: fault enable.
- fault_bit  output  BIT_W  to the core: bit index to flip.
- ciphertext  input  CT_W  from the core output.
- res_valid  output  1  result record available.
- res_ready  input  1  consumer accepts the record.
- res_bit  output  BIT_W  injected bit index for this record.
- res_ct  output  CT_W  faulty ciphertext.
- res_diff  output  CT_W  res_ct XOR golden.
- res_nbytes  output  5  count of non-zero bytes in res_diff, 0..16.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a sweep completes.

Behaviour:
- Reset (asynchronous, effective immediately): state IDLE; fault_en=0; fault_bit=0; res_valid=0; res_bit=0; res_ct=0; res_diff=0; res_nbytes=0; busy=0; done=0; golden register=0; counters=0.
- IDLE:
  - start=1 with bit_lo<=bit_hi: latch the range, set cur=bit_lo, go to GOLDEN.
  - start=1 with bit_lo>bit_hi: pulse done on the next cycle, stay IDLE, no injection, no records.
- GOLDEN:
  - Hold fault_en=0.
  - Wait LATENCY+1 cycles so any earlier fault is flushed, then latch ciphertext as golden and go to INJECT.
- INJECT (exactly one cycle):
  - fault_en=1 and fault_bit=cur.
  - Then go to WAIT; fault_en returns to 0.
- WAIT:
  - Count LATENCY cycles from the edge at which fault_en was registered high.
  - On that edge, register res_ct=ciphertext, res_diff=ciphertext^golden, res_nbytes, res_bit=cur.
  - Go to EMIT.
- EMIT:
  - Hold res_valid=1 with all res_* stable until res_valid&&res_ready.
  - On handshake, deassert res_valid.
  - If cur==bit_hi_latched: go to DONE.
  - Otherwise cur=cur+1 and go to INJECT.
  - No injection occurs while a record is pending.
- DONE (one cycle): done=1, then IDLE.
- start while busy is ignored.
- Counter widths:
  - cur comparison is made before increment, so bit_hi=127 never wraps cur to 0.
  - The LATENCY counter is sized clog2(LATENCY+2).
- Inter-injection spacing is at least LATENCY+2 cycles. Only one fault is ever in flight in the core pipeline.
- Reset mid-sweep (any state): immediate return to reset values; fault_en drops asynchronously; the partially collected record is discarded.
- res_nbytes counts bytes [8k+7:8k], k=0..15, where any bit differs.

Decomposition:
- Shared package fault_pkg holds:
  - state enum (IDLE, GOLDEN, INJECT, WAIT, EMIT, DONE);
  - AES_LATENCY=21, CT_W=128, BIT_W=7, NBYTES=16;
  - the result record struct {bit, ct, diff, nbytes}.
- One sub-module, byte_diff_count: combinational CT_W diff vector -> 5-bit count of non-zero bytes. Instantiated once in WAIT capture logic.

Test Plan:
- Single bit: reset, start with bit_lo=5, bit_hi=5.
  - fault_en high exactly 1 cycle with fault_bit=5.
  - Exactly one record, res_bit=5; res_diff equals model(faulty)^model(golden).
  - done pulses once; busy then falls.
- Full sweep: bit_lo=0, bit_hi=127, res_ready tied 1.
  - 128 records with res_bit 0..127 in order.
  - No wrap back to 0; injections spaced at least LATENCY+2 cycles.
  - done after the 128th handshake.
- Empty range: bit_lo=10, bit_hi=3.
  - done pulses one cycle after start.
  - fault_en never high; res_valid never high.
- Backpressure: range 0..2, res_ready low for 50 cycles on record 1.
  - res_* stable throughout; no fault_en pulse until handshake.
  - Records 0, 1, 2 in order.
- Diff count (stub core): stub core returns golden with byte0^=0x01 and byte15^=0xFF after injection.
  - res_nbytes=2; res_diff=0xFF00…0001.
- Reset mid-WAIT: assert rst_n low during WAIT of bit 3.
  - fault_en=0 and res_valid=0 immediately; busy=0.
  - A new start on range 7..7 yields exactly one record with res_bit=7.
